// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file: clear-FSM state,
// default geometry and the per-byte write merge.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_NUM_READ   = 2;

    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_b,
        input logic [7:0] new_b,
        input logic       mask
    );
        return mask ? new_b : old_b;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential clear engine: one entry zeroed per cycle, DEPTH cycles per sweep.
// Busy is registered (asserted the cycle after the start pulse); start requests during a sweep are ignored.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    output logic                  o_busy,
    output logic                  o_idle,
    output logic                  o_clr_vld,
    output logic [ADDR_WIDTH-1:0] o_clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

    clr_state_t            r_state;
    clr_state_t            w_next_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_next_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // The counter increment wraps naturally from DEPTH-1 back to 0 on the final sweep cycle.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (i_clear) begin
                    w_next_state = CLEAR;
                    w_next_cnt   = '0;
                end
            end
            CLEAR: begin
                w_next_cnt = r_cnt + 1'b1;
                if (r_cnt == LAST_IDX) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_comb begin
        o_busy     = (r_state == CLEAR);
        o_idle     = (r_state == IDLE);
        o_clr_vld  = (r_state == CLEAR);
        o_clr_addr = r_cnt;
    end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: byte-enable write port, NUM_READ zero-latency read ports, optional zero register,
// sequential clear engine (writes dropped while busy). Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_READ   = DEF_NUM_READ,
    parameter int ZERO_REG   = 1
) (
    input  logic                           clock,
    input  logic                           ctrl_reset_n,
    input  logic                           ctrl_writeEn,
    input  logic [ADDR_WIDTH-1:0]          ctrl_writeReg,
    input  logic [DATA_WIDTH/8-1:0]        ctrl_byteEn,
    input  logic [DATA_WIDTH-1:0]          data_writeReg,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ctrl_readReg,
    output logic [NUM_READ*DATA_WIDTH-1:0] data_readReg,
    input  logic                           ctrl_clear,
    output logic                           clear_busy
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_idle;
    logic                  w_clr_vld;
    logic [ADDR_WIDTH-1:0] w_clr_addr;
    logic                  w_zero_wr;
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_wr_old;
    logic [DATA_WIDTH-1:0] w_wr_merged;

    regfile_clear_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_fsm (
        .i_clk      (clock),
        .i_rst_n    (ctrl_reset_n),
        .i_clear    (ctrl_clear),
        .o_busy     (clear_busy),
        .o_idle     (w_idle),
        .o_clr_vld  (w_clr_vld),
        .o_clr_addr (w_clr_addr)
    );

    // A clear request in IDLE wins over a write in the same cycle; reset gating keeps reads at zero during reset.
    assign w_zero_wr = (ZERO_REG != 0) && (ctrl_writeReg == '0);
    assign w_wr_en   = ctrl_reset_n && ctrl_writeEn && w_idle && !ctrl_clear && !w_zero_wr;
    assign w_wr_old  = r_mem[ctrl_writeReg];

    for (genvar b = 0; b < NBYTES; b++) begin : g_merge
        assign w_wr_merged[8*b +: 8] = byte_merge(w_wr_old[8*b +: 8], data_writeReg[8*b +: 8], ctrl_byteEn[b]);
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_clr_vld) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_en) begin
            r_mem[ctrl_writeReg] <= w_wr_merged;
        end
    end

    logic [ADDR_WIDTH-1:0] w_rd_addr [NUM_READ];
    logic [DATA_WIDTH-1:0] w_rd_dat  [NUM_READ];

    for (genvar p = 0; p < NUM_READ; p++) begin : g_read
        assign w_rd_addr[p] = ctrl_readReg[p*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            w_rd_dat[p] = r_mem[w_rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
            if (w_wr_en && (w_rd_addr[p] == ctrl_writeReg)) begin
                w_rd_dat[p] = w_wr_merged;
            end
`endif
            if ((ZERO_REG != 0) && (w_rd_addr[p] == '0)) begin
                w_rd_dat[p] = '0;
            end
        end

        assign data_readReg[p*DATA_WIDTH +: DATA_WIDTH] = w_rd_dat[p];
    end

endmodule
